// File: rtl/muldiv_ctrl.sv
// Sequencer for the EX-stage multiplier/divider; owns the single HI/LO write port.
// Optional build macro MULDIV_DIVZERO_FAST_EN: a zero divisor skips the divider and completes at once.
module muldiv_ctrl #(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic [1:0]  hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_DONE = 3'd3,
        S_HOLD = 3'd4
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic              mul_signed_q, mul_signed_d;
    logic [31:0]       div_a_q, div_a_d, div_b_q, div_b_d;
    logic              div_signed_q, div_signed_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;

    // Next-state, operand capture and the combinational stall/write/divider controls
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_signed_d = div_signed_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        stallreq     = 1'b0;
        hilo_we      = 2'b00;
        hi_o         = hi_q;
        lo_o         = lo_q;
        div_start    = 1'b0;
        div_annul    = 1'b0;
        if (rst) begin
            // divider shares this reset, so no annul is sent
            state_d = S_IDLE;
            hi_o    = 32'd0;
            lo_o    = 32'd0;
        end else if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            div_annul = (state_q == S_DIV);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MULT, OP_MULTU: begin
                                mul_a_d      = src_a;
                                mul_b_d      = src_b;
                                mul_signed_d = (op_code == OP_MULT);
                                cnt_d        = '0;
                                stallreq     = 1'b1;
                                state_d      = S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                stallreq = 1'b1;
`ifdef MULDIV_DIVZERO_FAST_EN
                                if (src_b == 32'd0) begin
                                    hi_d    = src_a;
                                    lo_d    = 32'hFFFF_FFFF;
                                    state_d = S_DONE;
                                end else begin
                                    div_a_d      = src_a;
                                    div_b_d      = src_b;
                                    div_signed_d = (op_code == OP_DIV);
                                    state_d      = S_DIV;
                                end
`else
                                div_a_d      = src_a;
                                div_b_d      = src_b;
                                div_signed_d = (op_code == OP_DIV);
                                state_d      = S_DIV;
`endif
                            end
                            OP_MTHI: begin
                                hilo_we = 2'b10;
                                hi_o    = src_a;
                            end
                            OP_MTLO: begin
                                hilo_we = 2'b01;
                                lo_o    = src_a;
                            end
                            default: begin
                                state_d = S_IDLE;
                            end
                        endcase
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    stallreq = 1'b1;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        {hi_d, lo_d} = mul_result;
                        cnt_d        = '0;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_MUL;
                    end
                end
                S_DIV: begin
                    stallreq = 1'b1;
                    if (div_ready) begin
                        {hi_d, lo_d} = div_result;
                        state_d      = S_DONE;
                    end else begin
                        div_start = 1'b1;
                    end
                end
                S_DONE: begin
                    hilo_we = 2'b11;
                    state_d = ex_hold ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    // op is still presented; waiting here keeps it from re-issuing
                    state_d = ex_hold ? S_HOLD : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter, operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mul_a_q      <= 32'd0;
            mul_b_q      <= 32'd0;
            mul_signed_q <= 1'b0;
            div_a_q      <= 32'd0;
            div_b_q      <= 32'd0;
            div_signed_q <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_signed_q <= div_signed_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_signed = mul_signed_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign div_signed = div_signed_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl with simple multiplier/divider unit models
// and an arithmetic reference for HI/LO results, stall lengths and write counts.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;
`ifdef MULDIV_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk, rst, flush, ex_hold, op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a, src_b;
    logic        mul_signed, div_start, div_annul, div_signed, stallreq, busy;
    logic [31:0] mul_a, mul_b, div_a, div_b, hi_o, lo_o;
    logic [63:0] mul_prod_s, mul_pipe_q, div_res_q;
    logic        div_rdy_q;
    logic [1:0]  hilo_we;
    int          div_cnt, div_lat;
    int          n_checks, n_pass;

    muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
        .op_valid(op_valid), .op_code(op_code), .src_a(src_a), .src_b(src_b),
        .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_pipe_q),
        .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
        .div_a(div_a), .div_b(div_b), .div_ready(div_rdy_q), .div_result(div_res_q),
        .stallreq(stallreq), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] exp_hilo(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            3'd1:    return 64'(sa * sb);
            3'd2:    return {32'd0, a} * {32'd0, b};
            3'd3:    return div_ref(a, b, 1'b1);
            3'd4:    return div_ref(a, b, 1'b0);
            3'd5:    return {a, 32'd0};
            3'd6:    return {32'd0, a};
            default: return 64'd0;
        endcase
    endfunction

    // Multiplier model: product appears MUL_LAT cycles after operand capture
    always_comb begin
        if (mul_signed) mul_prod_s = 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
        else            mul_prod_s = {32'd0, mul_a} * {32'd0, mul_b};
    end
    always @(posedge clk) begin
        if (rst) mul_pipe_q <= 64'd0;
        else     mul_pipe_q <= mul_prod_s;
    end

    // Divider model: ready one cycle after div_lat cycles of div_start
    always @(posedge clk) begin
        if (rst || div_annul) begin
            div_cnt   <= 0;
            div_rdy_q <= 1'b0;
            div_res_q <= 64'd0;
        end else begin
            div_rdy_q <= 1'b0;
            if (div_start && !div_rdy_q) begin
                if (div_cnt == div_lat - 1) begin
                    div_cnt   <= 0;
                    div_rdy_q <= 1'b1;
                    div_res_q <= div_ref(div_a, div_b, div_signed);
                end else begin
                    div_cnt <= div_cnt + 1;
                end
            end else begin
                div_cnt <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Presents one op starting at posedge+1; returns at posedge+1 after it retires
    task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold);
        logic [63:0] exp;
        logic [1:0]  exp_we;
        logic        is_long, is_div, exp_ds, ds_seen;
        int          exp_stall, stalls, writes;
        exp     = exp_hilo(code, a, b);
        is_div  = (code == 3'd3) || (code == 3'd4);
        is_long = is_div || (code == 3'd1) || (code == 3'd2);
        exp_we  = is_long ? 2'b11 : (code == 3'd5) ? 2'b10 : (code == 3'd6) ? 2'b01 : 2'b00;
        if (is_div) exp_stall = (FAST && b == 32'd0) ? 1 : lat + 2;
        else if (is_long) exp_stall = MUL_LAT + 1;
        else exp_stall = 0;
        exp_ds  = is_div && !(FAST && b == 32'd0);
        div_lat = lat;
        op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
        ex_hold = is_long && (hold > 0);
        stalls = 0; writes = 0; ds_seen = 1'b0;
        @(negedge clk);
        chk("idle_at_issue", 64'(busy), 64'd0);
        while (stallreq && stalls < 300) begin
            stalls++;
            chk("we_during_stall", 64'(hilo_we), 64'd0);
            ds_seen = ds_seen | div_start;
            @(posedge clk); #1;
            src_a = $urandom; src_b = $urandom;
            @(negedge clk);
        end
        ds_seen = ds_seen | div_start;
        if (hilo_we != 2'b00) writes++;
        chk("stall_cycles", 64'(stalls), 64'(exp_stall));
        chk("hilo_we", 64'(hilo_we), 64'(exp_we));
        if (exp_we[1]) chk("hi", 64'(hi_o), 64'(exp[63:32]));
        if (exp_we[0]) chk("lo", 64'(lo_o), 64'(exp[31:0]));
        if (ex_hold) begin
            for (int i = 0; i <= hold; i++) begin
                @(posedge clk); #1;
                if (i == hold) ex_hold = 1'b0;
                @(negedge clk);
                chk("hold_busy", 64'(busy), 64'd1);
                if (hilo_we != 2'b00) writes++;
                ds_seen = ds_seen | div_start;
            end
        end
        chk("write_count", 64'(writes), 64'(exp_we != 2'b00));
        chk("div_start_seen", 64'(ds_seen), 64'(exp_ds));
        @(posedge clk); #1;
    endtask

    // Flush asserted in stall cycle k (0 = issue cycle) of the presented op
    task automatic do_flush(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input int k);
        logic exp_annul;
        int   writes;
        exp_annul = ((code == 3'd3) || (code == 3'd4)) && (k >= 1) && (k <= lat + 1)
                    && !(FAST && b == 32'd0);
        div_lat = lat;
        op_valid = 1'b1; op_code = code; src_a = a; src_b = b; ex_hold = 1'b0;
        writes = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (hilo_we != 2'b00) writes++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_annul", 64'(div_annul), 64'(exp_annul));
        chk("flush_we", 64'(hilo_we), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0; op_code = 3'd0;
        @(negedge clk);
        chk("flush_idle", 64'(busy), 64'd0);
        chk("annul_one_cycle", 64'(div_annul), 64'd0);
        if (hilo_we != 2'b00) writes++;
        chk("flush_writes", 64'(writes), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0; op_code = 3'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0; op_valid = 1'b0;
        op_code = 3'd0; src_a = 32'd0; src_b = 32'd0; div_lat = 4;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        chk("rst_we", 64'(hilo_we), 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_mul_ops", {mul_a, mul_b}, 64'd0);
        chk("rst_div_ops", {div_a, div_b}, 64'd0);
        chk("rst_ctl", 64'({mul_signed, div_signed, div_start, div_annul}), 64'd0);
        @(posedge clk); #1;

        do_op(3'd1, 32'hFFFF_FFFD, 32'd5, 4, 0);
        do_op(3'd4, 32'd100, 32'd7, 33, 0);
        do_op(3'd3, 32'hFFFF_FF9C, 32'd7, 5, 4);
        do_flush(3'd3, 32'd1000, 32'd9, 33, 10);
        do_op(3'd5, 32'h0000_1234, 32'd0, 4, 0);
        do_op(3'd6, 32'd5, 32'd0, 4, 0);
        do_op(3'd1, 32'd2, 32'd3, 4, 0);
        do_op(3'd3, 32'd7, 32'd0, 6, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 2);
        do_flush(3'd1, 32'd4, 32'd4, 4, 3);
        do_flush(3'd5, 32'h55, 32'd0, 4, 0);
        do_op(3'd0, 32'd1, 32'd1, 4, 0);
        do_op(3'd7, 32'd1, 32'd1, 4, 0);

        // reset in the middle of a divide
        div_lat = 20; op_valid = 1'b1; op_code = 3'd4; src_a = 32'd77; src_b = 32'd3;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_annul", 64'(div_annul), 64'd0);
        chk("rst_mid_we", 64'({hilo_we, stallreq}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0; op_code = 3'd0;
        @(negedge clk);
        chk("rst_mid_idle", 64'(busy), 64'd0);
        chk("rst_mid_ops", {div_a, div_b}, 64'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 60; n++) begin
            logic [2:0]  c;
            logic [31:0] ra, rb;
            int          rl, rh;
            c  = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else rb = 32'($urandom_range(1, 20));
            rl = int'($urandom_range(1, 12));
            rh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op(c, ra, rb, rl, rh);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
